// File: rtl/fu_out_buffer.sv
// Per-FU result queue between FU writeback and the CDB selector.
// Optional zero-latency bypass when empty: define FU_OUT_BUF_BYPASS_EN.
module fu_out_buffer #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 6
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     squash,
    input  logic                     fu_done,
    input  logic [DATA_W-1:0]        fu_data,
    input  logic [TAG_W-1:0]         fu_tag,
    output logic                     fu_stall,
    input  logic                     grant,
    output logic                     result_valid,
    output logic [DATA_W-1:0]        result_data,
    output logic [TAG_W-1:0]         result_tag,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [TAG_W-1:0]  mem_tag  [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;

    logic full;
    logic empty;
    logic byp;
    logic pop_ok;
    logic push_ok;
    logic wr_en;
    logic rd_en;
    logic drop;

    always_comb begin
        full  = (count == FULL_CNT);
        empty = (count == '0);
`ifdef FU_OUT_BUF_BYPASS_EN
        byp = empty && fu_done && !squash;
`else
        byp = 1'b0;
`endif
        result_valid = !empty || byp;
        pop_ok  = grant && result_valid && !squash;
        // A full queue still accepts a push when the head retires this cycle.
        push_ok = fu_done && !squash && (!full || pop_ok);
        wr_en   = push_ok && !(byp && pop_ok);
        rd_en   = pop_ok && !empty;
        drop    = fu_done && !squash && full && !pop_ok;
        fu_stall = full;
    end

    always_comb begin
        result_data = '0;
        result_tag  = '0;
        if (!empty) begin
            result_data = mem_data[head];
            result_tag  = mem_tag[head];
        end else if (byp) begin
            result_data = fu_data;
            result_tag  = fu_tag;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_data[tail] <= fu_data;
            mem_tag[tail]  <= fu_tag;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count    <= '0;
            head     <= '0;
            tail     <= '0;
            overflow <= 1'b0;
        end else begin
            if (drop)
                overflow <= 1'b1;
            if (squash) begin
                count <= '0;
                head  <= '0;
                tail  <= '0;
            end else begin
                if (wr_en)
                    tail <= tail + PTR_W'(1);
                if (rd_en)
                    head <= head + PTR_W'(1);
                case ({wr_en, rd_en})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fu_out_buffer.sv
// Self-checking bench for fu_out_buffer: directed table, corner sequences,
// and random traffic against a queue-based reference model.
module tb_fu_out_buffer;

    localparam int DEPTH  = 2;
    localparam int DATA_W = 32;
    localparam int TAG_W  = 6;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              squash = 1'b0;
    logic              fu_done = 1'b0;
    logic [DATA_W-1:0] fu_data = '0;
    logic [TAG_W-1:0]  fu_tag = '0;
    logic              fu_stall;
    logic              grant = 1'b0;
    logic              result_valid;
    logic [DATA_W-1:0] result_data;
    logic [TAG_W-1:0]  result_tag;
    logic [1:0]        count;
    logic              overflow;

    int n_tests = 0;
    int n_fail  = 0;

    fu_out_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
        .clock(clock), .reset(reset), .squash(squash),
        .fu_done(fu_done), .fu_data(fu_data), .fu_tag(fu_tag),
        .fu_stall(fu_stall), .grant(grant),
        .result_valid(result_valid), .result_data(result_data),
        .result_tag(result_tag), .count(count), .overflow(overflow)
    );

    always #5 clock = ~clock;

    function automatic logic [DATA_W-1:0] dat_of(input logic [TAG_W-1:0] t);
        return 32'hA5A5_0000 ^ {26'h0, t} ^ ({26'h0, t} << 8);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input logic sq, input logic dn, input logic [TAG_W-1:0] tg,
                         input logic gr);
        @(negedge clock);
        squash  = sq;
        fu_done = dn;
        fu_tag  = tg;
        fu_data = dat_of(tg);
        grant   = gr;
        #1;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        squash = 0; fu_done = 0; grant = 0; fu_tag = '0; fu_data = '0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    typedef struct {
        logic             sq;
        logic             dn;
        logic [TAG_W-1:0] tg;
        logic             gr;
        logic             ev;
        logic [TAG_W-1:0] et;
        int               ec;
        logic             es;
        logic             eo;
    } vec_t;

    vec_t vt[10];

    logic [DATA_W+TAG_W-1:0] q[$];
    logic                    m_ovf;

    initial begin
        // squash, done, tag, grant -> valid, tag, count, stall, overflow after edge
        vt[0] = '{0, 1, 6'd5,  0, 1, 6'd5, 1, 0, 0};
        vt[1] = '{0, 1, 6'd6,  0, 1, 6'd5, 2, 1, 0};
        vt[2] = '{0, 1, 6'd7,  0, 1, 6'd5, 2, 1, 1};
        vt[3] = '{0, 1, 6'd8,  1, 1, 6'd6, 2, 1, 1};
        vt[4] = '{0, 0, 6'd0,  1, 1, 6'd8, 1, 0, 1};
        vt[5] = '{0, 0, 6'd0,  1, 0, 6'd0, 0, 0, 1};
        vt[6] = '{0, 0, 6'd0,  1, 0, 6'd0, 0, 0, 1};
        vt[7] = '{0, 1, 6'd9,  0, 1, 6'd9, 1, 0, 1};
        vt[8] = '{1, 1, 6'd10, 1, 0, 6'd0, 0, 0, 1};
        vt[9] = '{0, 0, 6'd0,  0, 0, 6'd0, 0, 0, 1};

        #2;
        chk("rst_valid", 64'(result_valid), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_stall", 64'(fu_stall), 64'd0);
        chk("rst_ovf",   64'(overflow), 64'd0);
        chk("rst_data",  64'(result_data), 64'd0);
        do_reset();

        for (int i = 0; i < 10; i++) begin
            apply(vt[i].sq, vt[i].dn, vt[i].tg, vt[i].gr);
            tick();
            chk($sformatf("vec%0d_valid", i), 64'(result_valid), 64'(vt[i].ev));
            chk($sformatf("vec%0d_tag", i),   64'(result_tag), 64'(vt[i].et));
            chk($sformatf("vec%0d_data", i),  64'(result_data),
                vt[i].ev ? 64'(dat_of(vt[i].et)) : 64'd0);
            chk($sformatf("vec%0d_count", i), 64'(count), 64'(vt[i].ec));
            chk($sformatf("vec%0d_stall", i), 64'(fu_stall), 64'(vt[i].es));
            chk($sformatf("vec%0d_ovf", i),   64'(overflow), 64'(vt[i].eo));
        end

        // async reset mid-queue, overflow currently set
        apply(0, 1, 6'd11, 0);
        tick();
        apply(0, 1, 6'd12, 0);
        tick();
        apply(0, 0, 6'd0, 0);
        chk("mid_count_pre", 64'(count), 64'd2);
        #2;
        reset = 1'b1;
        #1;
        chk("async_count", 64'(count), 64'd0);
        chk("async_valid", 64'(result_valid), 64'd0);
        chk("async_ovf",   64'(overflow), 64'd0);
        do_reset();

        // wrap: one outstanding, five push/pop pairs
        apply(0, 1, 6'd1, 0);
        tick();
        for (int k = 2; k <= 6; k++) begin
            if (k <= 5) apply(0, 1, 6'(k), 1);
            else        apply(0, 0, 6'd0, 1);
            chk($sformatf("wrap_head%0d", k - 1), 64'(result_tag), 64'(k - 1));
            tick();
            chk($sformatf("wrap_cnt%0d", k - 1), 64'(count <= 2), 64'd1);
        end
        chk("wrap_empty", 64'(result_valid), 64'd0);

        // squash with push and grant at count=1; overflow must survive
        apply(0, 1, 6'd20, 0); tick();
        apply(0, 1, 6'd21, 0); tick();
        apply(0, 1, 6'd22, 0); tick();
        apply(0, 0, 6'd0, 1);  tick();
        chk("sq_pre_count", 64'(count), 64'd1);
        apply(1, 1, 6'd9, 1);
        tick();
        apply(0, 0, 6'd0, 0);
        chk("sq_count", 64'(count), 64'd0);
        chk("sq_valid", 64'(result_valid), 64'd0);
        chk("sq_ovf",   64'(overflow), 64'd1);
        do_reset();

        // bypass corner: empty, push + grant same cycle
        apply(0, 1, 6'd3, 1);
`ifdef FU_OUT_BUF_BYPASS_EN
        chk("byp_valid", 64'(result_valid), 64'd1);
        chk("byp_tag",   64'(result_tag), 64'd3);
        tick();
        chk("byp_count", 64'(count), 64'd0);
`else
        chk("byp_valid", 64'(result_valid), 64'd0);
        tick();
        chk("byp_count", 64'(count), 64'd1);
        chk("byp_tag",   64'(result_tag), 64'd3);
`endif
        do_reset();

        // random traffic against a FIFO model
        q.delete();
        m_ovf = 1'b0;
        for (int c = 0; c < 400; c++) begin
            logic sq, dn, gr, mv, pop, emp;
            logic [TAG_W-1:0] tg;
            logic [TAG_W-1:0] mtag;
            logic [DATA_W-1:0] mdat;
            sq = ($urandom_range(0, 15) == 0);
            dn = $urandom_range(0, 1) == 1;
            gr = $urandom_range(0, 1) == 1;
            tg = 6'($urandom);
            apply(sq, dn, tg, gr);
            emp = (q.size() == 0);
            mv = !emp;
            mtag = '0;
            mdat = '0;
            if (!emp) begin
                mtag = q[0][TAG_W-1:0];
                mdat = q[0][DATA_W+TAG_W-1:TAG_W];
            end
`ifdef FU_OUT_BUF_BYPASS_EN
            if (emp && dn && !sq) begin
                mv = 1'b1;
                mtag = tg;
                mdat = dat_of(tg);
            end
`endif
            chk("rnd_valid", 64'(result_valid), 64'(mv));
            chk("rnd_tag",   64'(result_tag), 64'(mtag));
            chk("rnd_data",  64'(result_data), 64'(mdat));
            chk("rnd_stall", 64'(fu_stall), 64'(q.size() == DEPTH));
            if (sq) begin
                q.delete();
            end else begin
                pop = gr && mv;
                if (dn && q.size() == DEPTH && !pop)
                    m_ovf = 1'b1;
                if (pop && !emp)
                    void'(q.pop_front());
                if (dn && !(pop && emp) && q.size() < DEPTH)
                    q.push_back({dat_of(tg), tg});
            end
            tick();
            chk("rnd_count", 64'(count), 64'(q.size()));
            chk("rnd_ovf",   64'(overflow), 64'(m_ovf));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
